// File: rtl/VX_gpu_pkg.sv
// Shared widths and helpers for the socket memory front end.
// Tag routing keeps the source index in the MSBs of the merged tag.
package VX_gpu_pkg;

   localparam int VX_DCR_ADDR_WIDTH = 12;
   localparam int VX_DCR_DATA_WIDTH = 32;

   typedef logic [VX_DCR_ADDR_WIDTH-1:0] dcr_addr_t;
   typedef logic [VX_DCR_DATA_WIDTH-1:0] dcr_data_t;

   function automatic int sel_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int out_tag_width(input int tag_w, input int n);
      return tag_w + sel_bits(n);
   endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer
// moves past the winner only when a grant is actually issued.
module vx_rr_arbiter
   import VX_gpu_pkg::*;
#(
   parameter int NUM_REQS = 4,
   localparam int IDX_W = sel_bits(NUM_REQS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_REQS-1:0] requests,
   input  logic                enable,
   output logic [NUM_REQS-1:0] grant,
   output logic [IDX_W-1:0]    grant_index,
   output logic                grant_valid
);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W:0]   idx;

   always_comb begin
      grant       = '0;
      grant_index = ptr;
      grant_valid = 1'b0;
      idx         = '0;
      for (int k = 0; k < NUM_REQS; k++) begin
         idx = {1'b0, ptr} + (IDX_W+1)'(k);
         if (idx >= (IDX_W+1)'(NUM_REQS))
            idx = idx - (IDX_W+1)'(NUM_REQS);
         if (enable && !grant_valid && requests[idx[IDX_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_index = idx[IDX_W-1:0];
         end
      end
      grant[grant_index] = grant_valid;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ptr <= '0;
      else if (grant_valid)
         ptr <= (grant_index == IDX_W'(NUM_REQS-1)) ? '0 : grant_index + 1'b1;
   end

endmodule

// File: rtl/vx_socket_mem_arbiter.sv
// Merges per-socket memory requests onto one port (source index in tag MSBs),
// routes responses back by that index, caps outstanding reads, broadcasts DCRs.
module vx_socket_mem_arbiter
   import VX_gpu_pkg::*;
#(
   parameter int NUM_INPUTS  = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 512,
   parameter int TAG_WIDTH   = 8,
   parameter int MAX_PENDING = 16,
   localparam int SEL_BITS      = sel_bits(NUM_INPUTS),
   localparam int OUT_TAG_WIDTH = out_tag_width(TAG_WIDTH, NUM_INPUTS),
   localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
   input  logic                             clk,
   input  logic                             reset_n,

   input  logic [NUM_INPUTS-1:0]            in_req_valid,
   input  logic [NUM_INPUTS-1:0]            in_req_rw,
   input  logic [NUM_INPUTS*ADDR_WIDTH-1:0] in_req_addr,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_req_data,
   input  logic [NUM_INPUTS*BE_WIDTH-1:0]   in_req_byteen,
   input  logic [NUM_INPUTS*TAG_WIDTH-1:0]  in_req_tag,
   output logic [NUM_INPUTS-1:0]            in_req_ready,

   output logic [NUM_INPUTS-1:0]            in_rsp_valid,
   output logic [DATA_WIDTH-1:0]            in_rsp_data,
   output logic [TAG_WIDTH-1:0]             in_rsp_tag,
   input  logic [NUM_INPUTS-1:0]            in_rsp_ready,

   output logic                             out_req_valid,
   output logic                             out_req_rw,
   output logic [ADDR_WIDTH-1:0]            out_req_addr,
   output logic [DATA_WIDTH-1:0]            out_req_data,
   output logic [BE_WIDTH-1:0]              out_req_byteen,
   output logic [OUT_TAG_WIDTH-1:0]         out_req_tag,
   input  logic                             out_req_ready,

   input  logic                             out_rsp_valid,
   input  logic [DATA_WIDTH-1:0]            out_rsp_data,
   input  logic [OUT_TAG_WIDTH-1:0]         out_rsp_tag,
   output logic                             out_rsp_ready,

   input  logic                             dcr_write_valid,
   input  logic [VX_DCR_ADDR_WIDTH-1:0]     dcr_write_addr,
   input  logic [VX_DCR_DATA_WIDTH-1:0]     dcr_write_data,
   output logic [NUM_INPUTS-1:0]            dcr_bcast_valid,
   output logic [VX_DCR_ADDR_WIDTH-1:0]     dcr_bcast_addr,
   output logic [VX_DCR_DATA_WIDTH-1:0]     dcr_bcast_data,

   input  logic [NUM_INPUTS-1:0]            socket_busy,
   output logic                             busy
);

   localparam int PW = $clog2(MAX_PENDING + 1);

   typedef struct packed {
      logic                     rw;
      logic [ADDR_WIDTH-1:0]    addr;
      logic [DATA_WIDTH-1:0]    data;
      logic [BE_WIDTH-1:0]      byteen;
      logic [OUT_TAG_WIDTH-1:0] tag;
   } mem_req_t;

   logic [PW-1:0]         pending [NUM_INPUTS];
   logic [NUM_INPUTS-1:0] eligible, grant, pend_inc, pend_dec, pend_nz;
   logic [SEL_BITS-1:0]   gidx, rsp_sel;
   logic                  enq, deq, can_enq, sel_ok, rsp_fire;
   mem_req_t              enq_entry;
   mem_req_t              fifo_q [2];
   logic                  wr_ptr, rd_ptr;
   logic [1:0]            count;

   // Writes never return a response, so only reads are held back by the cap.
   always_comb begin
      eligible = '0;
      pend_nz  = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         eligible[i] = in_req_valid[i] & (in_req_rw[i] | (pending[i] < PW'(MAX_PENDING)));
         pend_nz[i]  = (pending[i] != '0);
      end
   end

   vx_rr_arbiter #(.NUM_REQS(NUM_INPUTS)) u_arb (
      .clk         (clk),
      .reset_n     (reset_n),
      .requests    (eligible),
      .enable      (can_enq),
      .grant       (grant),
      .grant_index (gidx),
      .grant_valid (enq)
   );

   assign in_req_ready = grant;

   always_comb begin
      enq_entry.rw     = in_req_rw[gidx];
      enq_entry.addr   = in_req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
      enq_entry.data   = in_req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      enq_entry.byteen = in_req_byteen[int'(gidx)*BE_WIDTH +: BE_WIDTH];
      enq_entry.tag    = {gidx, in_req_tag[int'(gidx)*TAG_WIDTH +: TAG_WIDTH]};
   end

   // A full buffer still accepts when its head leaves in the same cycle.
   assign deq     = (count != 2'd0) & out_req_ready;
   assign can_enq = (count != 2'd2) | deq;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
      end else begin
         if (enq) fifo_q[wr_ptr] <= enq_entry;
         wr_ptr <= wr_ptr ^ enq;
         rd_ptr <= rd_ptr ^ deq;
         case ({enq, deq})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign out_req_valid  = (count != 2'd0);
   assign out_req_rw     = fifo_q[rd_ptr].rw;
   assign out_req_addr   = fifo_q[rd_ptr].addr;
   assign out_req_data   = fifo_q[rd_ptr].data;
   assign out_req_byteen = fifo_q[rd_ptr].byteen;
   assign out_req_tag    = fifo_q[rd_ptr].tag;

   assign rsp_sel     = out_rsp_tag[OUT_TAG_WIDTH-1 -: SEL_BITS];
   assign sel_ok      = ({1'b0, rsp_sel} < (SEL_BITS+1)'(NUM_INPUTS));
   assign in_rsp_data = out_rsp_data;
   assign in_rsp_tag  = out_rsp_tag[TAG_WIDTH-1:0];
   assign rsp_fire    = out_rsp_valid & out_rsp_ready;

   always_comb begin
      in_rsp_valid  = '0;
      out_rsp_ready = 1'b0;
      if (sel_ok) begin
         in_rsp_valid[rsp_sel] = out_rsp_valid;
         out_rsp_ready         = in_rsp_ready[rsp_sel];
      end
   end

   // A stray response on an idle counter is ignored here and flagged below.
   always_comb begin
      pend_inc = '0;
      pend_dec = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         pend_inc[i] = grant[i] & ~in_req_rw[i];
         pend_dec[i] = rsp_fire & (rsp_sel == SEL_BITS'(i)) & pend_nz[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_INPUTS; i++) pending[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (pend_inc[i] && !pend_dec[i])
               pending[i] <= pending[i] + PW'(1);
            else if (pend_dec[i] && !pend_inc[i])
               pending[i] <= pending[i] - PW'(1);
         end
      end
   end

   rsp_without_pending: assert property (@(posedge clk) disable iff (!reset_n)
      rsp_fire |-> (sel_ok && pend_nz[rsp_sel]))
      else $error("response for input %0d with no outstanding read", rsp_sel);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dcr_bcast_valid <= '0;
         dcr_bcast_addr  <= '0;
         dcr_bcast_data  <= '0;
         busy            <= 1'b0;
      end else begin
         dcr_bcast_valid <= {NUM_INPUTS{dcr_write_valid}};
         dcr_bcast_addr  <= dcr_write_addr;
         dcr_bcast_data  <= dcr_write_data;
         busy            <= (|socket_busy) | (|pend_nz) | (count != 2'd0);
      end
   end

endmodule

// File: tb/tb_vx_socket_mem_arbiter.sv
// Directed bench for vx_socket_mem_arbiter: 4 sockets, 32-bit data, read cap of 2.
module tb_vx_socket_mem_arbiter;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TW  = 8;
   localparam int OTW = 10;
   localparam int BEW = DW / 8;

   logic           clk;
   logic           reset_n;
   logic [N-1:0]   in_req_valid, in_req_rw, in_req_ready;
   logic [N*AW-1:0]  in_req_addr;
   logic [N*DW-1:0]  in_req_data;
   logic [N*BEW-1:0] in_req_byteen;
   logic [N*TW-1:0]  in_req_tag;
   logic [N-1:0]   in_rsp_valid, in_rsp_ready;
   logic [DW-1:0]  in_rsp_data;
   logic [TW-1:0]  in_rsp_tag;
   logic           out_req_valid, out_req_rw, out_req_ready;
   logic [AW-1:0]  out_req_addr;
   logic [DW-1:0]  out_req_data;
   logic [BEW-1:0] out_req_byteen;
   logic [OTW-1:0] out_req_tag;
   logic           out_rsp_valid, out_rsp_ready;
   logic [DW-1:0]  out_rsp_data;
   logic [OTW-1:0] out_rsp_tag;
   logic           dcr_write_valid;
   logic [11:0]    dcr_write_addr, dcr_bcast_addr;
   logic [31:0]    dcr_write_data, dcr_bcast_data;
   logic [N-1:0]   dcr_bcast_valid;
   logic [N-1:0]   socket_busy;
   logic           busy;

   int passed = 0;
   int total  = 0;

   vx_socket_mem_arbiter #(
      .NUM_INPUTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_PENDING(2)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
      .in_req_data(in_req_data), .in_req_byteen(in_req_byteen), .in_req_tag(in_req_tag),
      .in_req_ready(in_req_ready),
      .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
      .in_rsp_ready(in_rsp_ready),
      .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
      .out_req_data(out_req_data), .out_req_byteen(out_req_byteen), .out_req_tag(out_req_tag),
      .out_req_ready(out_req_ready),
      .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
      .out_rsp_ready(out_rsp_ready),
      .dcr_write_valid(dcr_write_valid), .dcr_write_addr(dcr_write_addr),
      .dcr_write_data(dcr_write_data),
      .dcr_bcast_valid(dcr_bcast_valid), .dcr_bcast_addr(dcr_bcast_addr),
      .dcr_bcast_data(dcr_bcast_data),
      .socket_busy(socket_busy), .busy(busy)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive request inputs, then check grant and output head mid-cycle
   task automatic step(input string name, input logic [N-1:0] v, input logic [N-1:0] rw,
                       input logic ordy, input logic [N-1:0] exp_grant,
                       input logic exp_oval, input logic [OTW-1:0] exp_otag);
      in_req_valid  = v;
      in_req_rw     = rw;
      out_req_ready = ordy;
      #3;
      chk({name, "_ready"}, in_req_ready, exp_grant);
      chk({name, "_oval"}, out_req_valid, exp_oval);
      if (exp_oval) chk({name, "_otag"}, out_req_tag, exp_otag);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      in_req_valid = '0; in_req_rw = '0; out_req_ready = 1'b0;
      in_rsp_ready = '0; out_rsp_valid = 1'b0; out_rsp_data = '0; out_rsp_tag = '0;
      dcr_write_valid = 1'b0; dcr_write_addr = '0; dcr_write_data = '0;
      socket_busy = '0;
      for (int i = 0; i < N; i++) begin
         in_req_addr[i*AW +: AW]    = 32'h100 * i;
         in_req_data[i*DW +: DW]    = 32'hD000_0000 + i;
         in_req_byteen[i*BEW +: BEW] = 4'hF;
         in_req_tag[i*TW +: TW]     = 8'h10 + 8'(i);
      end

      // reset state
      tick();
      tick();
      chk("rst_oval", out_req_valid, 1'b0);
      chk("rst_ready", in_req_ready, 4'b0000);
      chk("rst_dcr", dcr_bcast_valid, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      reset_n = 1'b1;
      tick();

      // single read from input 2, tag routed back
      in_req_tag[2*TW +: TW]  = 8'h5A;
      in_req_addr[2*AW +: AW] = 32'h1000;
      step("t1_acc", 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, '0);
      tick();
      step("t1_out", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 10'h25A);
      chk("t1_addr", out_req_addr, 32'h1000);
      chk("t1_rw", out_req_rw, 1'b0);
      tick();
      out_rsp_valid = 1'b1; out_rsp_tag = 10'h25A; out_rsp_data = 32'hCAFE0001;
      in_rsp_ready  = 4'b1011;
      #1;
      chk("t1_rsp_blocked", out_rsp_ready, 1'b0);
      in_rsp_ready = 4'b0100;
      #1;
      chk("t1_rsp_rdy", out_rsp_ready, 1'b1);
      chk("t1_rsp_valid", in_rsp_valid, 4'b0100);
      chk("t1_rsp_tag", in_rsp_tag, 8'h5A);
      chk("t1_rsp_data", in_rsp_data, 32'hCAFE0001);
      chk("t1_busy_pend", busy, 1'b1);
      tick();
      out_rsp_valid = 1'b0; in_rsp_ready = '0;
      tick();
      chk("t1_pend_clear", busy, 1'b0);
      in_req_tag[2*TW +: TW]  = 8'h12;
      in_req_addr[2*AW +: AW] = 32'h200;

      // round-robin streaming, then backpressure with all inputs valid
      do_reset();
      step("rr0", 4'hF, 4'hF, 1'b1, 4'b0001, 1'b0, '0);     tick();
      step("rr1", 4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 10'h010); tick();
      step("rr2", 4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 10'h111); tick();
      step("rr3", 4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 10'h212); tick();
      step("rr4", 4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 10'h313); tick();
      step("rr5", 4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 10'h010); tick();
      step("rr6", 4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 10'h111); tick();
      step("rr7", 4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 10'h212); tick();
      step("rr8", 4'h0, 4'hF, 1'b1, 4'b0000, 1'b1, 10'h313); tick();
      step("bp0", 4'hF, 4'hF, 1'b0, 4'b0001, 1'b0, '0);     tick();
      step("bp1", 4'hF, 4'hF, 1'b0, 4'b0010, 1'b1, 10'h010); tick();
      step("bp2", 4'hF, 4'hF, 1'b0, 4'b0000, 1'b1, 10'h010); tick();
      step("bp3", 4'hF, 4'hF, 1'b0, 4'b0000, 1'b1, 10'h010); tick();
      step("bp4", 4'hF, 4'hF, 1'b0, 4'b0000, 1'b1, 10'h010); tick();
      step("rl0", 4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 10'h010); tick();
      step("rl1", 4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 10'h111); tick();
      step("rl2", 4'h0, 4'hF, 1'b1, 4'b0000, 1'b1, 10'h212); tick();
      step("rl3", 4'h0, 4'hF, 1'b1, 4'b0000, 1'b1, 10'h313); tick();
      step("rl4", 4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, '0);     tick();

      // read cap of 2 on input 0; writes still pass
      step("cap0", 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, '0);     tick();
      step("cap1", 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 10'h010); tick();
      step("cap2", 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b1, 10'h010); tick();
      step("cap3", 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, '0);     tick();
      out_rsp_valid = 1'b1; out_rsp_tag = 10'h010; in_rsp_ready = 4'b0001;
      step("cap4", 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b1, 10'h010);
      chk("cap4_wr", out_req_rw, 1'b1);
      chk("cap4_rsp", in_rsp_valid, 4'b0001);
      tick();
      out_rsp_valid = 1'b0; in_rsp_ready = '0;
      step("cap5", 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, '0);     tick();
      step("cap6", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 10'h010);
      chk("cap6_rd", out_req_rw, 1'b0);
      tick();

      // DCR broadcast
      dcr_write_valid = 1'b1; dcr_write_addr = 12'h001; dcr_write_data = 32'hDEADBEEF;
      #2;
      chk("dcr_pre", dcr_bcast_valid, 4'b0000);
      tick();
      dcr_write_valid = 1'b0; dcr_write_addr = 12'h0; dcr_write_data = 32'h0;
      #2;
      chk("dcr_valid", dcr_bcast_valid, 4'b1111);
      chk("dcr_addr", dcr_bcast_addr, 12'h001);
      chk("dcr_data", dcr_bcast_data, 32'hDEADBEEF);
      chk("dcr_busy", busy, 1'b1);
      tick();
      #2;
      chk("dcr_post", dcr_bcast_valid, 4'b0000);
      tick();

      // async reset with buffer full and reads outstanding
      step("fill0", 4'b0011, 4'b0011, 1'b0, 4'b0010, 1'b0, '0);     tick();
      step("fill1", 4'b0011, 4'b0011, 1'b0, 4'b0001, 1'b1, 10'h111); tick();
      in_req_valid = '0;
      #1;
      chk("pre_rst_oval", out_req_valid, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("arst_oval", out_req_valid, 1'b0);
      chk("arst_ready", in_req_ready, 4'b0000);
      chk("arst_busy", busy, 1'b0);
      chk("arst_dcr", dcr_bcast_valid, 4'b0000);
      tick();
      tick();
      reset_n = 1'b1;
      socket_busy = 4'b0010;
      tick();
      chk("sb_busy", busy, 1'b1);
      socket_busy = '0;
      step("post3", 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0, '0); tick();
      step("post3_out", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 10'h313);
      chk("post_busy", busy, 1'b0);
      tick();
      out_rsp_valid = 1'b1; out_rsp_tag = 10'h313; in_rsp_ready = 4'b1000;
      #2;
      chk("post_rsp", in_rsp_valid, 4'b1000);
      chk("post_rsp_tag", in_rsp_tag, 8'h13);
      tick();
      out_rsp_valid = 1'b0; in_rsp_ready = '0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
